key_event: RTL

- Consumer of the debounced, active-high key level produced by the key debouncer (1 = pressed).
- Turns the clean level into single-cycle event pulses: down, up, single click, double click, long press and auto-repeat.
- Sits between the debouncer and application logic such as mode selection and counters; one instance per key.

---
 rtl/key_pkg.sv | 33 +++
 rtl/key_edge.sv | 44 ++++
 rtl/key_event.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared types and constants for the key event block: one-hot
//            FSM state encodings, default 50 MHz timing constants and the
//            short timing constants used for simulation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

  // One-hot gesture states; any other pattern is treated as illegal.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PRESS1 = 5'b00010,
    ST_WAIT2  = 5'b00100,
    ST_PRESS2 = 5'b01000,
    ST_LONG   = 5'b10000
  } key_state_e;

  // Default timing at 50 MHz.
  localparam int unsigned c_long_cnt_50m   = 50_000_000;  // 1 s
  localparam int unsigned c_dclick_cnt_50m = 15_000_000;  // 300 ms
  localparam int unsigned c_repeat_cnt_50m = 5_000_000;   // 100 ms
  localparam int unsigned c_cnt_w_50m      = 26;

  // Short timing for simulation.
  localparam int unsigned c_sim_long_cnt   = 20;
  localparam int unsigned c_sim_dclick_cnt = 10;
  localparam int unsigned c_sim_repeat_cnt = 4;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Purpose  : Registers the previous key level and flags rising and falling
//            edges of the incoming level.
// Ports    : clk   - system clock
//            rst   - synchronous active-low reset
//            level - debounced key level (1 = pressed)
//            rise  - level went 0 -> 1 since last cycle (combinational)
//            fall  - level went 1 -> 0 since last cycle (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module key_edge #(
  // Previous-level value forced by reset. A value of 1 hides a key that is
  // already held when reset releases until it is released and pressed again.
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q <= RESET_VAL;
    end else begin
      level_q <= level_d;
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule : key_edge
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// ============================================================================
// Module   : key_event
// Purpose  : Turns a debounced key level into one-cycle event pulses: press,
//            release, single click, double click, long press and auto-repeat.
// Ports    : clk        - system clock
//            rst        - synchronous active-low reset
//            key_state  - debounced key level (1 = pressed)
//            key_down   - pulse on each accepted press edge
//            key_up     - pulse on each release edge
//            key_click  - pulse when a single short press is confirmed
//            key_dclick - pulse when a double press is confirmed
//            key_long   - pulse when the hold reaches LONG_CNT cycles
//            key_repeat - pulse every REPEAT_CNT cycles while long-held
//            key_busy   - high while a gesture is in progress
// Revision : 1.0 - initial release
// ============================================================================
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = c_long_cnt_50m,
  parameter int unsigned DCLICK_CNT = c_dclick_cnt_50m,
  parameter int unsigned REPEAT_CNT = c_repeat_cnt_50m,
  parameter int unsigned CNT_W      = c_cnt_w_50m
) (
  input  logic clk,
  input  logic rst,
  input  logic key_state,
  output logic key_down,
  output logic key_up,
  output logic key_click,
  output logic key_dclick,
  output logic key_long,
  output logic key_repeat,
  output logic key_busy
);

  // Terminal counts: each timer runs 0..N-1 and acts on the N-1 edge.
  localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CNT - 1);

  logic w_rise;
  logic w_fall;

  key_edge #(
    .RESET_VAL (1'b1)
  ) u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .level (key_state),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  key_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             down_q,   down_d;
  logic             up_q,     up_d;
  logic             click_q,  click_d;
  logic             dclick_q, dclick_d;
  logic             long_q,   long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q,   busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    // Press/release pulses follow the edges regardless of gesture state.
    down_d   = w_rise;
    up_d     = w_fall;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_rise) begin
          state_d = ST_PRESS1;
        end
      end

      ST_PRESS1: begin
        // Release wins over the long-press threshold on the same edge.
        if (w_fall) begin
          state_d = ST_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == c_long_last) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT2: begin
        // A second press on the closing edge of the window still counts.
        if (w_rise) begin
          state_d = ST_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == c_dclick_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PRESS2: begin
        cnt_d = '0;
        if (w_fall) begin
          state_d  = ST_IDLE;
          dclick_d = 1'b1;
        end
      end

      ST_LONG: begin
        if (w_fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_repeat_last) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // Non-one-hot state: recover silently.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      down_q   <= 1'b0;
      up_q     <= 1'b0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      down_q   <= down_d;
      up_q     <= up_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign key_down   = down_q;
  assign key_up     = up_q;
  assign key_click  = click_q;
  assign key_dclick = dclick_q;
  assign key_long   = long_q;
  assign key_repeat = repeat_q;
  assign key_busy   = busy_q;

endmodule : key_event
`default_nettype wire
